b2s_tx_arbiter: RTL

Shares one b2s single-wire line among NREQ requesters: arbitrates, latches the winner's word, then drives the b2s waveform (start pulse, then WIDTH pulse-width-coded bits, LSB first, then an idle gap). It sits upstream of a b2s_receiver on the same `clk` frequency. It also replaces per-source transmitters on shared-link boards.

---
 rtl/b2s_pkg.sv | 36 +++
 rtl/b2s_tx_arbiter_if.sv | 26 ++
 rtl/b2s_rr_arbiter.sv | 68 ++++++
 rtl/b2s_tx_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/b2s_pkg.sv
// b2s_pkg: shared b2s timing defaults, receiver windows and tx states.
// Imported by the transmit arbiter, its sub-module and the bench.
package b2s_pkg;

  localparam int B2S_T_START = 20;
  localparam int B2S_T_ONE   = 10;
  localparam int B2S_T_ZERO  = 30;
  localparam int B2S_T_HIGH  = 10;
  localparam int B2S_T_GAP   = 40;

  localparam int B2S_START_MIN = 16;
  localparam int B2S_START_MAX = 24;
  localparam int B2S_ONE_MIN   = 6;
  localparam int B2S_ONE_MAX   = 14;
  localparam int B2S_ZERO_MIN  = 26;
  localparam int B2S_ZERO_MAX  = 34;

  typedef enum logic [2:0] {
    IDLE,
    START_LO,
    HIGH,
    BIT_LO,
    GAP
  } b2s_state_e;

  function automatic int max5(int a, int b, int c, int d, int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/b2s_tx_arbiter_if.sv
// b2s_tx_arbiter_if: requester-side bundle of the shared b2s transmitter.
// master = requesters / bench, slave = the arbiter.
interface b2s_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [IW-1:0]         gnt_id;
  logic                  busy;
  logic                  b2s_dout;

  modport master (
    output req, din,
    input  ack, gnt_id, busy, b2s_dout
  );

  modport slave (
    input  req, din,
    output ack, gnt_id, busy, b2s_dout
  );

endinterface

// File: rtl/b2s_rr_arbiter.sv
// b2s_rr_arbiter: picks one requester; round-robin by default,
// lowest-index-wins when B2S_ARB_FIXED_PRIO_EN is defined.
module b2s_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

`ifdef B2S_ARB_FIXED_PRIO_EN

  logic unused_arb;
  assign unused_arb = ^{clk, rst, advance_i};

  // lowest requesting index wins
  always_comb begin
    idx_o = '0;
    gnt_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
      end
    end
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end

`else

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  // search from last winner + 1, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    cand  = 0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IW-1:0];
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

  // pointer moves to the winner only when a grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = idx_o;
  end

  // pointer register; reset value makes req0 win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/b2s_tx_arbiter.sv
// b2s_tx_arbiter: shares one b2s line among NREQ requesters.
// Build option: B2S_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module b2s_tx_arbiter
  import b2s_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int T_START = B2S_T_START,
  parameter int T_ONE   = B2S_T_ONE,
  parameter int T_ZERO  = B2S_T_ZERO,
  parameter int T_HIGH  = B2S_T_HIGH,
  parameter int T_GAP   = B2S_T_GAP
) (
  input logic               clk,
  input logic               rst,
  b2s_tx_arbiter_if.slave   bus
);

  localparam int IW   = $clog2(NREQ);
  localparam int TMAX = max5(T_START, T_ONE, T_ZERO, T_HIGH, T_GAP);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int CW   = $clog2(WIDTH + 1);

  b2s_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [IW-1:0]    gid_q, gid_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             cap;
  logic             tdone;

  b2s_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req),
    .advance_i (cap),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx)
  );

  // serializer next state; a pending request is taken straight out
  // of the last GAP cycle so back-to-back frames lose no idle clock
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    ack_d   = '0;
    cap     = 1'b0;
    tdone   = (timer_q == '0);
    unique case (state_q)
      IDLE: begin
        dout_d = 1'b1;
        busy_d = 1'b0;
        cap    = |bus.req;
      end
      START_LO: begin
        if (tdone) begin
          state_d = HIGH;
          dout_d  = 1'b1;
          timer_d = TW'(T_HIGH - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HIGH: begin
        if (!tdone) begin
          timer_d = timer_q - TW'(1);
        end else if (cnt_q != '0) begin
          state_d = BIT_LO;
          dout_d  = 1'b0;
          timer_d = sr_q[0] ? TW'(T_ONE - 1) : TW'(T_ZERO - 1);
        end else begin
          state_d = GAP;
          timer_d = TW'(T_GAP - 1);
        end
      end
      BIT_LO: begin
        if (tdone) begin
          state_d = HIGH;
          dout_d  = 1'b1;
          timer_d = TW'(T_HIGH - 1);
          sr_d    = {1'b0, sr_q[WIDTH-1:1]};
          cnt_d   = cnt_q - CW'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (tdone) begin
          cap = |bus.req;
          if (!cap) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      state_d = START_LO;
      dout_d  = 1'b0;
      busy_d  = 1'b1;
      ack_d   = arb_gnt;
      gid_d   = arb_idx;
      sr_d    = bus.din[arb_idx*WIDTH +: WIDTH];
      cnt_d   = CW'(WIDTH);
      timer_d = TW'(T_START - 1);
    end
  end

  // state registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.gnt_id   = gid_q;
  assign bus.busy     = busy_q;
  assign bus.b2s_dout = dout_q;

endmodule
